// File: rtl/servo_pkg.sv
// servo_pkg: servo frame/pulse constants and FSM state encoding, shared with the upstream slew stage.
package servo_pkg;
  localparam int SERVO_MAX_DEG = 180;
  localparam int FRAME_TICKS_DEF = 1000000;
  localparam int MIN_TICKS_DEF = 50000;
  localparam int TICKS_PER_DEG_DEF = 278;
  localparam int LEAD_DEF = 16;
  typedef enum logic [2:0] {IDLE, MUL, WAIT, HIGH, LOW} servo_state_t;
endpackage

// File: rtl/servo_mul8x9.sv
// servo_mul8x9: shift-add p = c + a*b, one multiplier bit per cycle; p valid and done high 8 cycles after start.
module servo_mul8x9 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [8:0]  b,
  input  logic [16:0] c,
  output logic        done,
  output logic [16:0] p
);
  logic [7:0] sh;
  logic [16:0] bs;
  logic [2:0] i;
  logic busy;
  // The start edge already consumes a[0], so seven further edges finish the product.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sh <= '0;
      bs <= '0;
      i <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      p <= '0;
    end else if (start) begin
      p <= c + (a[0] ? {8'd0, b} : 17'd0);
      sh <= a >> 1;
      bs <= {7'd0, b, 1'b0};
      i <= 3'd1;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      p <= p + (sh[0] ? bs : 17'd0);
      sh <= sh >> 1;
      bs <= bs << 1;
      i <= i + 3'd1;
      busy <= i != 3'd7;
      done <= i == 3'd7;
    end
endmodule

// File: rtl/servo_pwm.sv
// servo_pwm: frame-based servo pulse generator; angle/en are latched once per frame and the
// pulse width MIN_TICKS + angle*TICKS_PER_DEG is built by a serial multiplier at frame start.
module servo_pwm
  import servo_pkg::*;
#(
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int MIN_TICKS = MIN_TICKS_DEF,
  parameter int TICKS_PER_DEG = TICKS_PER_DEG_DEF,
  parameter int LEAD = LEAD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] angle,
  input  logic       en,
  output logic       pwm,
  output logic       frame_start,
  output logic [7:0] angle_q,
  output logic       clamped
);
  localparam logic [19:0] LAST = 20'(FRAME_TICKS - 1);
  localparam logic [19:0] LEAD_M1 = 20'(LEAD - 1);
  localparam logic [7:0] MAX_DEG = 8'(SERVO_MAX_DEG);
  if (LEAD + MIN_TICKS + SERVO_MAX_DEG * TICKS_PER_DEG >= FRAME_TICKS || LEAD < 9) begin : g_bad_params
    $error("servo_pwm: pulse cannot fit in frame or LEAD too small for multiplier");
  end
  logic [19:0] frame_cnt;
  logic [16:0] pulse_ticks, width;
  logic en_q, sample, mul_done;
  servo_state_t state, state_n;
  assign sample = frame_cnt == LAST;
  servo_mul8x9 u_mul (
    .clk(clk),
    .rst(rst),
    .start(state == MUL && frame_cnt == 20'd0),
    .a(angle_q),
    .b(9'(TICKS_PER_DEG)),
    .c(17'(MIN_TICKS)),
    .done(mul_done),
    .p(pulse_ticks)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE, LOW: if (sample) state_n = MUL;
      MUL:       if (frame_cnt == 20'd7) state_n = WAIT;
      WAIT:      if (frame_cnt == LEAD_M1 && mul_done) state_n = HIGH;
      HIGH:      if (width == 17'd1) state_n = LOW;
      default:   state_n = IDLE;
    endcase
  end
  // en_q only changes on the sample edge, so a pulse in flight always runs to full width.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      frame_cnt <= LAST;
      frame_start <= 1'b0;
      en_q <= 1'b0;
      angle_q <= '0;
      clamped <= 1'b0;
      width <= '0;
      pwm <= 1'b0;
    end else begin
      state <= state_n;
      frame_cnt <= sample ? 20'd0 : frame_cnt + 20'd1;
      frame_start <= sample;
      if (sample) begin
        angle_q <= angle > MAX_DEG ? MAX_DEG : angle;
        clamped <= angle > MAX_DEG;
        en_q <= en;
      end
      width <= state_n == HIGH ? (state == HIGH ? width - 17'd1 : pulse_ticks) : 17'd0;
      pwm <= state_n == HIGH && en_q;
    end
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: frame-level reference checks of servo_pwm with shortened frame parameters.
module tb_servo_pwm;
  localparam int FT = 1200;
  localparam int MT = 100;
  localparam int TPD = 5;
  localparam int LD = 16;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [7:0] angle = 8'd0;
  logic pwm, frame_start, clamped;
  logic [7:0] angle_q;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  servo_pwm #(.FRAME_TICKS(FT), .MIN_TICKS(MT), .TICKS_PER_DEG(TPD), .LEAD(LD)) dut (
    .clk(clk),
    .rst(rst),
    .angle(angle),
    .en(en),
    .pwm(pwm),
    .frame_start(frame_start),
    .angle_q(angle_q),
    .clamped(clamped)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, $signed(got), $signed(exp), $time);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_pwm", pwm, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_angle_q", angle_q, 0);
    check("rst_clamped", clamped, 0);
    repeat (3) @(posedge clk);
    #1 check("rst_hold_pwm", pwm, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask
  // One frame: drive inputs before the sample edge, optionally disturb them mid-frame or reset.
  task automatic run_frame(input logic [7:0] ang, input logic e, input int chg,
                           input logic [7:0] ang2, input logic e2, input int rst_at);
    int aq, width_exp, hi, first, fs;
    aq = ang > 180 ? 180 : int'(ang);
    width_exp = MT + aq * TPD;
    hi = 0;
    first = -1;
    fs = 0;
    angle = ang;
    en = e;
    for (int c = 0; c < FT; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        check("frame_start_at_0", frame_start, 1);
        check("angle_q", angle_q, aq);
        check("clamped", clamped, ang > 180);
      end
      fs += int'(frame_start);
      hi += int'(pwm);
      if (pwm && first < 0) first = c;
      if (c == rst_at) begin
        check("pwm_before_rst", pwm, e);
        do_reset();
        return;
      end
      if (c == chg) begin
        angle = ang2;
        en = e2;
      end
    end
    check("frame_start_count", fs, 1);
    check("pulse_start", first, e ? LD : -1);
    check("pulse_width", hi, e ? width_exp : 0);
    check("angle_q_hold", angle_q, aq);
    check("clamped_hold", clamped, ang > 180);
  endtask
  initial begin
    do_reset();
    run_frame(8'd60, 1'b1, -1, 8'd0, 1'b0, -1);
    run_frame(8'd0, 1'b1, -1, 8'd0, 1'b0, -1);
    run_frame(8'd180, 1'b1, -1, 8'd0, 1'b0, -1);
    run_frame(8'd90, 1'b1, -1, 8'd0, 1'b0, -1);
    run_frame(8'd200, 1'b1, -1, 8'd0, 1'b0, -1);
    run_frame(8'd100, 1'b1, -1, 8'd0, 1'b0, -1);
    run_frame(8'd0, 1'b1, 30, 8'd180, 1'b1, -1);
    run_frame(8'd180, 1'b1, -1, 8'd0, 1'b0, -1);
    run_frame(8'd0, 1'b1, 20, 8'd0, 1'b0, -1);
    run_frame(8'd0, 1'b0, -1, 8'd0, 1'b0, -1);
    run_frame(8'd255, 1'b1, -1, 8'd0, 1'b0, -1);
    run_frame(8'd181, 1'b1, 50, 8'd3, 1'b0, -1);
    run_frame(8'd0, 1'b1, -1, 8'd0, 1'b0, 40);
    run_frame(8'd60, 1'b1, -1, 8'd0, 1'b0, -1);
    for (int k = 0; k < 18; k++)
      run_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, int'($urandom_range(1, FT - 2)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/servo_pwm.md
SERVO_PWM -- requirements
Module: servo_pwm

Interface
REQ-001 Parameter FRAME_TICKS, default 1000000, meaning clk cycles per servo frame (20 ms at 50 MHz).
REQ-002 Parameter MIN_TICKS, default 50000, meaning pulse width at 0 degrees (1.0 ms).
REQ-003 Parameter TICKS_PER_DEG, default 278, meaning pulse width added per degree (9 bits max).
REQ-004 Parameter LEAD, default 16, meaning frame_cnt value at which the pulse rises.
REQ-005 clk  input  1  clock; reset rst, asynchronous, active-low; clock clk.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 angle  input  8  target angle in degrees, driven by the upstream slew stage; may change on any cycle.
REQ-008 en  input  1  pulse enable; sampled once per frame.
REQ-009 pwm  output  1  registered servo pulse.
REQ-010 frame_start  output  1  registered one-cycle strobe, high while frame_cnt==0.
REQ-011 angle_q  output  8  angle latched for the current frame, after clamping.
REQ-012 clamped  output  1  high for the whole frame when the latched angle was clamped.

Function
REQ-013 frame_cnt SHALL be 20 bits, count 0..FRAME_TICKS-1, wrap to 0, and never stall.
REQ-014 On the edge where frame_cnt==FRAME_TICKS-1, the block SHALL sample inputs: angle_q<=min(angle,180); clamped<=(angle>180); en_q<=en.
REQ-015 Changes on angle or en at any other time SHALL NOT affect the frame in progress.
REQ-016 pulse_ticks (17 bits) SHALL equal MIN_TICKS + angle_q*TICKS_PER_DEG, computed with a shift-add multiplier, one bit per cycle, 8 cycles, no hardware multiplier.
REQ-017 The FSM SHALL have states IDLE, MUL, WAIT, HIGH and LOW.
- IDLE: only after reset; go to MUL on the first sample edge.
- MUL: frame_cnt 0..7; go to WAIT after 8 iterations, with pulse_ticks valid by frame_cnt==8.
- WAIT: go to HIGH on the edge where frame_cnt==LEAD-1.
- HIGH: go to LOW after pulse_ticks cycles.
- LOW: go to MUL on the next sample edge.
REQ-018 When en_q==1, pwm SHALL be high for exactly pulse_ticks cycles, during frame_cnt LEAD..LEAD+pulse_ticks-1, and low otherwise.
REQ-019 When en_q==0, the FSM SHALL still sequence through its states, but pwm SHALL stay low for the whole frame.
REQ-020 Deasserting en mid-pulse SHALL NOT truncate the pulse; it takes effect at the next frame.
REQ-021 The width counter SHALL be loaded with pulse_ticks on HIGH entry and decrement to zero; pwm falls on the edge where the counter reaches 1.
REQ-022 An elaboration check SHALL fail when LEAD+MIN_TICKS+180*TICKS_PER_DEG >= FRAME_TICKS, or when LEAD < 9.
REQ-023 angle==180 SHALL NOT assert clamped; angle 181..255 SHALL assert it.

Reset
REQ-024 While rst==0, outputs and state SHALL be: pwm=0, frame_start=0, angle_q=0, clamped=0, en_q=0, state=IDLE, frame_cnt=FRAME_TICKS-1, width counter=0, pulse_ticks=0.
REQ-025 Asserting rst mid-pulse SHALL drive pwm low asynchronously, with no glitch extension.
REQ-026 The first clk edge after rst release SHALL be a sample edge, so the first frame starts immediately.

Structure
REQ-027 SERVO_MAX_DEG=180 and the default frame/pulse constants SHALL be defined in the shared servo package, also used by the upstream slew stage.
REQ-028 The shift-add multiplier SHALL be a sub-module servo_mul8x9 with start/done handshake, latency 8 cycles.
REQ-029 The state encoding SHALL be a package typedef.

Verification (default parameters)
REQ-030 rst release, angle=60, en=1 -> frame_start at frame_cnt 0; pwm high for 66680 cycles starting at frame_cnt 16; period 1000000.
REQ-031 angle=0 -> 50000-cycle pulse; angle=180 -> 100040-cycle pulse with clamped=0; angle=90 -> 75020-cycle pulse.
REQ-032 angle=200 -> angle_q=180, clamped=1, 100040-cycle pulse; next frame with angle=100 -> clamped=0, 77800-cycle pulse.
REQ-033 angle changed 0->180 at frame_cnt 30000, mid-pulse -> current pulse remains 50000 cycles; next frame 100040 cycles.
REQ-034 en dropped at frame_cnt 20000 -> current pulse completes at 50000 cycles; next frame pwm stays low, frame_start still pulses.
REQ-035 rst asserted at frame_cnt 40000 with pwm high -> pwm=0 immediately; after release, a full new pulse begins at frame_cnt 16.
